// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
// Serialises one command frame per accepted request:
//    CMD bit (1 = write, 0 = read) | address field | data field (writes only)
//    | optional even-parity bit
// Each field goes out LSB first or MSB first depending on MSB_FIRST. Every bit
// is held on tx_bit with valid=1 until the receiver takes it with ready=1.
// A one-cycle DONE state (done=1) closes the frame before returning to IDLE.
//
// Ports
//    clk        system clock, rising-edge active
//    reset      asynchronous active-low reset
//    start      frame request, only looked at in IDLE
//    write      frame type, latched on accept (1 = address+data, 0 = address)
//    addr_in    address, latched on accept
//    data_in    write data, latched on accept
//    ready      receiver takes the presented bit on this edge
//    tx_bit     serial bit (forced to 0 whenever valid=0)
//    valid      tx_bit carries a frame bit
//    busy       high in every state except IDLE
//    done       one-cycle end-of-frame pulse
//    state_out  current state code, zero-extended to 5 bits
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module serial_frame_tx #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b0,
   parameter bit PARITY_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  ready,
   output logic                  tx_bit,
   output logic                  valid,
   output logic                  busy,
   output logic                  done,
   output logic [4:0]            state_out
);

   // The bit counter only has to reach the last index of the wider field.
   localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_WIDTH = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   typedef enum logic [4:0] {
      S_IDLE   = 5'd0,
      S_CMD    = 5'd1,
      S_ADDR   = 5'd2,
      S_DATA   = 5'd3,
      S_PARITY = 5'd4,
      S_DONE   = 5'd5
   } state_t;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------

   // Running even parity: fold one transferred bit into the accumulator.
   function automatic logic parity_step(input logic acc, input logic bit_v);
      return acc ^ bit_v;
   endfunction

   // Bit currently at the head of the address shifter.
   function automatic logic addr_head(input logic [ADDR_WIDTH-1:0] v);
      return MSB_FIRST ? v[ADDR_WIDTH-1] : v[0];
   endfunction

   // Bit currently at the head of the data shifter.
   function automatic logic data_head(input logic [DATA_WIDTH-1:0] v);
      return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
   endfunction

   // Advance the address shifter by one bit in the configured order.
   function automatic logic [ADDR_WIDTH-1:0] addr_shift(input logic [ADDR_WIDTH-1:0] v);
      return MSB_FIRST ? (v << 1'b1) : (v >> 1'b1);
   endfunction

   // Advance the data shifter by one bit in the configured order.
   function automatic logic [DATA_WIDTH-1:0] data_shift(input logic [DATA_WIDTH-1:0] v);
      return MSB_FIRST ? (v << 1'b1) : (v >> 1'b1);
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                  state_r,  state_s;
   logic [CNT_WIDTH-1:0]    cnt_r,    cnt_s;
   logic                    write_r,  write_s;
   logic [ADDR_WIDTH-1:0]   addr_r,   addr_s;
   logic [DATA_WIDTH-1:0]   data_r,   data_s;
   logic                    par_r,    par_s;
   logic                    tx_bit_r, tx_bit_s;
   logic                    valid_r,  valid_s;
   logic                    busy_r,   busy_s;
   logic                    done_r,   done_s;
   logic                    xfer_s;
   logic                    head_s;

   // A bit leaves only when it is being presented and the receiver accepts it.
   assign xfer_s = valid_r & ready;

   // Next-state, field sequencing and latch updates.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      write_s = write_r;
      addr_s  = addr_r;
      data_s  = data_r;
      par_s   = par_r;

      case (state_r)
         S_IDLE: begin
            if (start) begin
               write_s = write;
               addr_s  = addr_in;
               data_s  = data_in;
               par_s   = 1'b0;
               cnt_s   = CNT_ZERO;
               state_s = S_CMD;
            end else begin
               state_s = S_IDLE;
            end
         end

         S_CMD: begin
            if (xfer_s) begin
               par_s   = parity_step(par_r, tx_bit_r);
               cnt_s   = CNT_ZERO;
               state_s = S_ADDR;
            end else begin
               state_s = S_CMD;
            end
         end

         S_ADDR: begin
            if (xfer_s) begin
               par_s  = parity_step(par_r, tx_bit_r);
               addr_s = addr_shift(addr_r);
               if (cnt_r == ADDR_LAST) begin
                  cnt_s = CNT_ZERO;
                  if (write_r) begin
                     state_s = S_DATA;
                  end else if (PARITY_EN) begin
                     state_s = S_PARITY;
                  end else begin
                     state_s = S_DONE;
                  end
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               state_s = S_ADDR;
            end
         end

         S_DATA: begin
            if (xfer_s) begin
               par_s  = parity_step(par_r, tx_bit_r);
               data_s = data_shift(data_r);
               if (cnt_r == DATA_LAST) begin
                  cnt_s = CNT_ZERO;
                  if (PARITY_EN) begin
                     state_s = S_PARITY;
                  end else begin
                     state_s = S_DONE;
                  end
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               state_s = S_DATA;
            end
         end

         S_PARITY: begin
            if (xfer_s) begin
               cnt_s   = CNT_ZERO;
               state_s = S_DONE;
            end else begin
               state_s = S_PARITY;
            end
         end

         S_DONE: begin
            state_s = S_IDLE;
         end

         // Unused codes recover to IDLE on the next edge.
         default: begin
            cnt_s   = CNT_ZERO;
            state_s = S_IDLE;
         end
      endcase
   end

   // Output decode from the *next* state so every output can be a flop.
   always_comb begin
      head_s = 1'b0;
      case (state_s)
         S_CMD:    head_s = write_s;
         S_ADDR:   head_s = addr_head(addr_s);
         S_DATA:   head_s = data_head(data_s);
         S_PARITY: head_s = par_s;
         default:  head_s = 1'b0;
      endcase

      case (state_s)
         S_CMD, S_ADDR, S_DATA, S_PARITY: valid_s = 1'b1;
         default:                          valid_s = 1'b0;
      endcase

      if (valid_s) begin
         tx_bit_s = head_s;
      end else begin
         tx_bit_s = 1'b0;
      end

      busy_s = (state_s != S_IDLE);
      done_s = (state_s == S_DONE);
   end

   // State, counter, latches and output flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= S_IDLE;
         cnt_r    <= CNT_ZERO;
         write_r  <= 1'b0;
         addr_r   <= '0;
         data_r   <= '0;
         par_r    <= 1'b0;
         tx_bit_r <= 1'b0;
         valid_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         write_r  <= write_s;
         addr_r   <= addr_s;
         data_r   <= data_s;
         par_r    <= par_s;
         tx_bit_r <= tx_bit_s;
         valid_r  <= valid_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   assign tx_bit    = tx_bit_r;
   assign valid     = valid_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign state_out = state_r;

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
// Directed bench for serial_frame_tx. Two instances share the stimulus:
// dut_a uses the default parameters, dut_b is MSB-first without parity.
// Expected bits of each frame are pushed to a queue when the frame is
// requested and popped as the selected instance transfers them.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          write;
   logic [AW-1:0] addr_in;
   logic [DW-1:0] data_in;
   logic          ready;

   logic          tx_a, valid_a, busy_a, done_a;
   logic [4:0]    st_a;
   logic          tx_b, valid_b, busy_b, done_b;
   logic [4:0]    st_b;

   logic          sel_b;
   logic          mon_tx, mon_valid, mon_busy, mon_done;
   logic [4:0]    mon_state;

   int            n_cmp = 0;
   int            n_err = 0;
   logic          exp_q[$];

   always #5 clk = ~clk;

   serial_frame_tx #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start), .write(write),
      .addr_in(addr_in), .data_in(data_in), .ready(ready),
      .tx_bit(tx_a), .valid(valid_a), .busy(busy_a), .done(done_a),
      .state_out(st_a)
   );

   serial_frame_tx #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start), .write(write),
      .addr_in(addr_in), .data_in(data_in), .ready(ready),
      .tx_bit(tx_b), .valid(valid_b), .busy(busy_b), .done(done_b),
      .state_out(st_b)
   );

   assign mon_tx    = sel_b ? tx_b    : tx_a;
   assign mon_valid = sel_b ? valid_b : valid_a;
   assign mon_busy  = sel_b ? busy_b  : busy_a;
   assign mon_done  = sel_b ? done_b  : done_a;
   assign mon_state = sel_b ? st_b    : st_a;

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Reference frame: cmd, address, data (writes), running even parity.
   task automatic push_frame(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit msb, input bit par);
      logic acc;
      logic b;
      acc = w;
      exp_q.push_back(w);
      for (int i = 0; i < AW; i++) begin
         b = a[msb ? (AW - 1 - i) : i];
         acc = acc ^ b;
         exp_q.push_back(b);
      end
      if (w) begin
         for (int i = 0; i < DW; i++) begin
            b = d[msb ? (DW - 1 - i) : i];
            acc = acc ^ b;
            exp_q.push_back(b);
         end
      end
      if (par) exp_q.push_back(acc);
   endtask

   // Called on a negedge; returns on the negedge right after acceptance.
   task automatic begin_frame(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      start   = 1'b1;
      write   = w;
      addr_in = a;
      data_in = d;
      @(negedge clk);
      start = 1'b0;
      chk_i("accept_state", int'(mon_state), 1);
      chk1("accept_valid", mon_valid, 1'b1);
      chk1("accept_busy", mon_busy, 1'b1);
   endtask

   // Consume the frame bit by bit. stall_at: transfer index held with
   // ready=0 for 3 cycles; mid_at: transfer index where start is raised and
   // the inputs change; abort_at: transfer index where control returns early.
   task automatic drain(input int len, input int stall_at, input int mid_at,
                        input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                        input int abort_at);
      int   n;
      int   k;
      bit   seen;
      logic hold_tx;
      logic [4:0] hold_st;
      logic e;
      n = 0;
      k = 1;
      seen = 1'b0;
      while (!seen && k <= len + 10) begin
         if (n == abort_at) return;
         if (mon_done) begin
            seen = 1'b1;
         end else begin
            if (mon_valid && n == stall_at) begin
               ready   = 1'b0;
               hold_tx = mon_tx;
               hold_st = mon_state;
               for (int s = 0; s < 3; s++) begin
                  @(negedge clk);
                  k++;
                  chk1("stall_tx", mon_tx, hold_tx);
                  chk1("stall_valid", mon_valid, 1'b1);
                  chk_i("stall_state", int'(mon_state), int'(hold_st));
               end
               ready = 1'b1;
            end
            if (n == mid_at) begin
               start   = 1'b1;
               write   = w2;
               addr_in = a2;
               data_in = d2;
            end
            if (mon_valid && ready) begin
               if (exp_q.size() == 0) begin
                  chk_i("extra_bit", n, len);
               end else begin
                  e = exp_q.pop_front();
                  chk1($sformatf("bit%0d", n), mon_tx, e);
               end
               n++;
            end
            @(negedge clk);
            k++;
         end
      end
      chk1("done_seen", seen, 1'b1);
      chk_i("transfers", n, len);
      chk_i("done_cycle", k, len + 1 + ((stall_at >= 0) ? 3 : 0));
      chk1("done_valid", mon_valid, 1'b0);
      chk1("done_tx", mon_tx, 1'b0);
      chk1("done_busy", mon_busy, 1'b1);
      chk_i("queue_empty", exp_q.size(), 0);
      @(negedge clk);
      chk1("idle_busy", mon_busy, 1'b0);
      chk1("idle_done", mon_done, 1'b0);
      chk_i("idle_state", int'(mon_state), 0);
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      write   = 1'b0;
      addr_in = '0;
      data_in = '0;
      ready   = 1'b1;
      sel_b   = 1'b0;

      // Reset state
      #1;
      chk1("rst_tx", tx_a, 1'b0);
      chk1("rst_valid", valid_a, 1'b0);
      chk1("rst_busy", busy_a, 1'b0);
      chk1("rst_done", done_a, 1'b0);
      chk_i("rst_state", int'(st_a), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Read frame 0xA5C
      push_frame(1'b0, 12'hA5C, 8'h00, 1'b0, 1'b1);
      begin_frame(1'b0, 12'hA5C, 8'h00);
      drain(14, -1, -1, 1'b0, 12'h000, 8'h00, -1);

      // Write frame 0x001 / 0x80
      push_frame(1'b1, 12'h001, 8'h80, 1'b0, 1'b1);
      begin_frame(1'b1, 12'h001, 8'h80);
      drain(22, -1, -1, 1'b0, 12'h000, 8'h00, -1);

      // Read frame with a 3-cycle stall on address bit 4 (transfer index 5)
      push_frame(1'b0, 12'hA5C, 8'h00, 1'b0, 1'b1);
      begin_frame(1'b0, 12'hA5C, 8'h00);
      drain(14, 5, -1, 1'b0, 12'h000, 8'h00, -1);

      // start raised mid-ADDR with new inputs, held through DONE
      push_frame(1'b0, 12'h3C5, 8'h00, 1'b0, 1'b1);
      begin_frame(1'b0, 12'h3C5, 8'h00);
      drain(14, -1, 3, 1'b1, 12'hF0F, 8'h5A, -1);
      push_frame(1'b1, 12'hF0F, 8'h5A, 1'b0, 1'b1);
      begin_frame(1'b1, 12'hF0F, 8'h5A);
      drain(22, -1, -1, 1'b0, 12'h000, 8'h00, -1);

      // Asynchronous reset in DATA (transfer index 16)
      push_frame(1'b1, 12'h123, 8'hA7, 1'b0, 1'b1);
      begin_frame(1'b1, 12'h123, 8'hA7);
      drain(22, -1, -1, 1'b0, 12'h000, 8'h00, 16);
      chk_i("pre_abort_state", int'(st_a), 3);
      #1;
      reset = 1'b0;
      start = 1'b1;
      #1;
      chk1("arst_valid", valid_a, 1'b0);
      chk1("arst_busy", busy_a, 1'b0);
      chk1("arst_done", done_a, 1'b0);
      chk1("arst_tx", tx_a, 1'b0);
      chk_i("arst_state", int'(st_a), 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      chk_i("rst_start_ignored", int'(st_a), 0);
      chk1("rst_hold_busy", busy_a, 1'b0);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk1("post_rst_done", done_a, 1'b0);
      chk_i("post_rst_state", int'(st_a), 0);
      push_frame(1'b0, 12'h5A3, 8'h00, 1'b0, 1'b1);
      begin_frame(1'b0, 12'h5A3, 8'h00);
      drain(14, -1, -1, 1'b0, 12'h000, 8'h00, -1);

      // MSB-first, no parity: read frame 0x800 on dut_b
      sel_b = 1'b1;
      push_frame(1'b0, 12'h800, 8'h00, 1'b1, 1'b0);
      begin_frame(1'b0, 12'h800, 8'h00);
      drain(13, -1, -1, 1'b0, 12'h000, 8'h00, -1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
